// File: rtl/eth_pkg.sv
// Shared Ethernet MII constants: receive FSM encodings, CRC-32 parameters and
// preamble/SFD nibbles used by both transmit and receive paths.
package eth_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPreamble = 3'd1,
        StData     = 3'd2,
        StCheck    = 3'd3,
        StDrop     = 3'd4
    } rx_state_e;

    localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
    localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
    // Register value left after a frame plus its own FCS has been run through the CRC.
    localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

    localparam logic [3:0] NibPreamble = 4'h5;
    localparam logic [3:0] NibSfd      = 4'hD;

    localparam int unsigned ETH_FRAME_SIZE = 1400;

endpackage

// File: rtl/crc32_nibble.sv
// Combinational reflected CRC-32 step over one nibble, LSB first.
module crc32_nibble
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [3:0]  nibble_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nibble_i[i]) begin
                c = (c >> 1) ^ CrcPoly;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/mii_receive_and_fcs_checker.sv
// MII receive path: strips preamble/SFD, writes frame bytes to buffer RAM and
// checks the trailing FCS, reporting length and good/bad status per frame.
module mii_receive_and_fcs_checker
    import eth_pkg::*;
#(
    parameter int unsigned MAX_FRAME_SIZE = ETH_FRAME_SIZE,
    parameter int unsigned MIN_FRAME_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MII_RXD,
    input  logic        MII_RX_DV,
    input  logic        MII_RX_ER,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_wr_en,
    output logic [10:0] frame_len,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [2:0]  FSM_state
);

    localparam logic [10:0] MaxCnt = 11'(MAX_FRAME_SIZE + 4);
    localparam logic [10:0] MinCnt = 11'(MIN_FRAME_SIZE);

    rx_state_e   state_q, state_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_nib_q, low_nib_d;
    logic [10:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic        ram_wr_en_q, ram_wr_en_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_error_q, frame_error_d;
    logic [31:0] crc_next;

    crc32_nibble u_crc (
        .crc_i    (crc_q),
        .nibble_i (MII_RXD),
        .crc_o    (crc_next)
    );

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        crc_d         = crc_q;
        phase_d       = phase_q;
        low_nib_d     = low_nib_q;
        ram_addr_d    = ram_addr_q;
        ram_din_d     = ram_din_q;
        ram_wr_en_d   = 1'b0;
        frame_len_d   = frame_len_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;

        unique case (state_q)
            StDrop: begin
                if (!MII_RX_DV) state_d = StIdle;
            end
            StIdle: begin
                if (MII_RX_DV) state_d = (MII_RXD == NibPreamble) ? StPreamble : StDrop;
            end
            StPreamble: begin
                if (!MII_RX_DV) begin
                    state_d = StIdle;
                end else if (MII_RXD == NibSfd) begin
                    state_d    = StData;
                    byte_cnt_d = '0;
                    phase_d    = 1'b0;
                    crc_d      = CrcInit;
                end else if (MII_RXD != NibPreamble) begin
                    state_d = StDrop;
                end
            end
            StData: begin
                if (!MII_RX_DV) begin
                    state_d = StCheck;
                end else if (MII_RX_ER) begin
                    state_d       = StDrop;
                    frame_error_d = 1'b1;
                end else begin
                    crc_d   = crc_next;
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        low_nib_d = MII_RXD;
                    end else if (byte_cnt_q == MaxCnt) begin
                        // Oversized frame: the overflowing byte is never written.
                        state_d       = StDrop;
                        frame_error_d = 1'b1;
                    end else begin
                        ram_din_d   = {MII_RXD, low_nib_q};
                        ram_addr_d  = byte_cnt_q;
                        ram_wr_en_d = 1'b1;
                        byte_cnt_d  = byte_cnt_q + 11'd1;
                    end
                end
            end
            StCheck: begin
                state_d = StIdle;
                if (!phase_q && (byte_cnt_q >= MinCnt) && (crc_q == CrcResidue)) begin
                    frame_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
                frame_len_d = (byte_cnt_q >= 11'd4) ? (byte_cnt_q - 11'd4) : '0;
            end
            default: state_d = StDrop;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StDrop;
            byte_cnt_q    <= '0;
            crc_q         <= CrcInit;
            phase_q       <= 1'b0;
            low_nib_q     <= '0;
            ram_addr_q    <= '0;
            ram_din_q     <= '0;
            ram_wr_en_q   <= 1'b0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            crc_q         <= crc_d;
            phase_q       <= phase_d;
            low_nib_q     <= low_nib_d;
            ram_addr_q    <= ram_addr_d;
            ram_din_q     <= ram_din_d;
            ram_wr_en_q   <= ram_wr_en_d;
            frame_len_q   <= frame_len_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign frame_len   = frame_len_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign FSM_state   = state_q;

endmodule

// File: tb/tb_mii_receive_and_fcs_checker.sv
// Scoreboard bench: stimulus pushes expected RAM writes and frame pulses,
// a monitor pops and compares them whenever the DUT presents an output.
module tb_mii_receive_and_fcs_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rxd = 4'h0;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_wr_en;
    logic [10:0] frame_len;
    logic        frame_valid;
    logic        frame_error;
    logic [2:0]  fsm_state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit          good;
        bit          chk_len;
        logic [10:0] len;
    } pulse_t;

    wr_t        wr_q[$];
    pulse_t     pl_q[$];
    logic [7:0] fb[$];

    always #20 clk = ~clk;

    mii_receive_and_fcs_checker dut (
        .clk         (clk),
        .reset       (reset),
        .MII_RXD     (rxd),
        .MII_RX_DV   (dv),
        .MII_RX_ER   (er),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_wr_en   (ram_wr_en),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .FSM_state   (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else r = r >> 1;
        end
        return r;
    endfunction

    // Payload i&0xFF, optional FCS (LSB byte first), optional flip of last byte bit 0.
    task automatic build_frame(input int len, input bit add_fcs, input bit corrupt);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        fb = {};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            b = 8'(i);
            fb.push_back(b);
            c = crc_byte(c, b);
        end
        if (add_fcs) begin
            fcs = ~c;
            for (int k = 0; k < 4; k++) fb.push_back(fcs[8*k +: 8]);
        end
        if (corrupt) fb[fb.size()-1] = fb[fb.size()-1] ^ 8'h01;
    endtask

    task automatic send_nib(input logic [3:0] n, input logic e);
        @(negedge clk);
        rxd = n;
        dv  = 1'b1;
        er  = e;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[3:0], 1'b0);
        send_nib(b[7:4], 1'b0);
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b0);
        send_nib(4'hD, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv  = 1'b0;
            er  = 1'b0;
            rxd = 4'h0;
        end
    endtask

    // Sends fb after preamble; expects writes for the first 1404 bytes only.
    task automatic send_frame();
        send_preamble();
        for (int i = 0; i < fb.size(); i++) begin
            if (i < 1404) wr_q.push_back('{addr: 11'(i), data: fb[i]});
            send_byte(fb[i]);
        end
        idle_cycles(8);
    endtask

    task automatic expect_pulse(input bit good, input bit chk_len, input int len);
        pl_q.push_back('{good: good, chk_len: chk_len, len: 11'(len)});
    endtask

    initial begin : monitor
        wr_t    w;
        pulse_t p;
        forever begin
            @(posedge clk);
            #1;
            if (frame_valid && frame_error) check("pulse_exclusive", 32'd1, 32'd0);
            if (ram_wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(ram_addr), 32'h7FF);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(w.addr));
                    check("wr_data", 32'(ram_din), 32'(w.data));
                end
            end
            if (frame_valid || frame_error) begin
                if (pl_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, frame_valid, frame_error}, 32'd0);
                end else begin
                    p = pl_q.pop_front();
                    check("pulse_valid", 32'(frame_valid), 32'(p.good));
                    check("pulse_error", 32'(frame_error), 32'(!p.good));
                    if (p.chk_len) check("frame_len", 32'(frame_len), 32'(p.len));
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(fsm_state), 32'd4);
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_din", 32'(ram_din), 32'd0);
        check("rst_len", 32'(frame_len), 32'd0);
        check("rst_pulses", {30'd0, frame_valid, frame_error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("drop_to_idle", 32'(fsm_state), 32'd0);

        // Good 60-byte frame.
        build_frame(60, 1'b1, 1'b0);
        expect_pulse(1'b1, 1'b1, 60);
        send_frame();
        check("len_held", 32'(frame_len), 32'd60);

        // Corrupted FCS.
        build_frame(60, 1'b1, 1'b1);
        expect_pulse(1'b0, 1'b1, 60);
        send_frame();

        // Receive error at byte 20.
        build_frame(60, 1'b1, 1'b0);
        send_preamble();
        for (int i = 0; i < 20; i++) begin
            wr_q.push_back('{addr: 11'(i), data: fb[i]});
            send_byte(fb[i]);
        end
        expect_pulse(1'b0, 1'b0, 0);
        send_nib(fb[20][3:0], 1'b1);
        send_nib(fb[20][7:4], 1'b0);
        for (int i = 21; i < fb.size(); i++) send_byte(fb[i]);
        #1;
        check("er_drop_state", 32'(fsm_state), 32'd4);
        idle_cycles(3);
        #1;
        check("er_idle_state", 32'(fsm_state), 32'd0);
        idle_cycles(4);

        // Oversized frame: writes stop at 1403.
        build_frame(1410, 1'b1, 1'b0);
        expect_pulse(1'b0, 1'b0, 0);
        send_frame();

        // Lone nibble after SFD.
        send_preamble();
        send_nib(4'hA, 1'b0);
        expect_pulse(1'b0, 1'b1, 0);
        idle_cycles(8);

        // Runt frame with valid FCS.
        build_frame(40, 1'b1, 1'b0);
        expect_pulse(1'b0, 1'b1, 40);
        send_frame();

        // Reset released mid-frame: nothing expected.
        @(negedge clk);
        reset = 1'b0;
        build_frame(60, 1'b1, 1'b0);
        send_preamble();
        for (int i = 0; i < 10; i++) send_byte(fb[i]);
        reset = 1'b1;
        for (int i = 10; i < fb.size(); i++) send_byte(fb[i]);
        #1;
        check("mid_reset_drop", 32'(fsm_state), 32'd4);
        idle_cycles(8);
        expect_pulse(1'b1, 1'b1, 60);
        send_frame();

        waited = 0;
        while ((wr_q.size() != 0 || pl_q.size() != 0) && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        check("writes_drained", 32'(wr_q.size()), 32'd0);
        check("pulses_drained", 32'(pl_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mii_receive_and_fcs_checker.md
# mii_receive_and_fcs_checker

Receive-side counterpart of the Ethernet MII transmit path. Samples 4-bit MII receive nibbles from the PHY, strips preamble/SFD, assembles bytes and writes them into a frame buffer RAM from address 0. Checks the trailing CRC-32 FCS and reports each frame's length and good/bad status to the control logic. It sits between the PHY pins and the buffer RAM, in the same place as the transmit controller but facing the other way.

## Interface
Parameters:
- MAX_FRAME_SIZE, 1400: largest accepted frame in bytes, excluding FCS; sets the RAM window.
- MIN_FRAME_SIZE, 64: smallest accepted frame in bytes, including FCS.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  MII receive clock, 25 MHz; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MII_RXD  in  4  receive nibble from the PHY.
- MII_RX_DV  in  1  receive data valid.
- MII_RX_ER  in  1  receive error.
- ram_addr  out  11  byte write address.
- ram_din  out  8  byte to write.
- ram_wr_en  out  1  one-cycle write strobe.
- frame_len  out  11  payload byte count of the last frame, excluding FCS; held until the next frame ends.
- frame_valid  out  1  one-cycle pulse when a frame ends with a good FCS.
- frame_error  out  1  one-cycle pulse when a frame ends bad.
- FSM_state  out  3  current state encoding, for debug.

## Operation
- States: IDLE=0, PREAMBLE=1, DATA=2, CHECK=3, DROP=4.
- Reset: state DROP; all outputs 0; byte count 0; CRC = 0xFFFFFFFF.
- DROP:
  - Discards input until MII_RX_DV=0, then goes to IDLE.
  - This prevents joining a frame that is already in progress after reset.
  - Entering DROP from DATA raises frame_error once.
- IDLE → PREAMBLE when MII_RX_DV=1 and MII_RXD=0x5.
- IDLE → DROP when MII_RX_DV=1 with any other nibble.
- PREAMBLE, while MII_RX_DV=1:
  - 0x5: stay.
  - 0xD: SFD. Go to DATA; clear byte count, nibble phase and CRC.
  - Any other nibble: go to DROP.
- PREAMBLE with MII_RX_DV=0: back to IDLE, with no pulse.
- DATA, nibble handling:
  - The low nibble arrives first. The byte is {second, first}.
  - On each second nibble: ram_din = byte, ram_addr = byte count, ram_wr_en = 1, then byte count increments.
  - The CRC is updated on every nibble, including the FCS nibbles. The FCS bytes are also written to RAM.
- DATA, abort conditions:
  - MII_RX_ER=1 while MII_RX_DV=1: go to DROP and pulse frame_error.
  - Byte count reaches MAX_FRAME_SIZE+4 and another byte completes: that byte is not written; go to DROP and pulse frame_error.
- DATA with MII_RX_DV=0: go to CHECK. The CHECK decision below runs on the next cycle.
- CHECK (one cycle), then IDLE:
  - Good frame: odd nibble count = 0, byte count ≥ MIN_FRAME_SIZE, and CRC residue = 0xDEBB20E3. Pulse frame_valid.
  - Otherwise: pulse frame_error.
  - Either way, frame_len = byte count − 4, saturating at 0.
- CRC arithmetic:
  - Reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Processes 4 bits per clock, LSB first, matching transmit FCS generation.
- Asserting reset mid-frame returns the block to DROP immediately, with no pulse.

## Timing
- Write latency: ram_wr_en is high in the cycle after the second nibble of a byte is sampled. Back-to-back bytes give one strobe every 2 clocks.
- The frame_valid or frame_error pulse comes 2 cycles after the first sample with MII_RX_DV=0.
- frame_len is updated in the same cycle as the pulse.
- frame_valid and frame_error are never high together.
- A new preamble can be accepted in the cycle after CHECK. The IFG is not enforced.
- The RAM port is write-only, with no backpressure. The reader must consume the frame before the next SFD; later frames overwrite from address 0.

## Structure
- Shared package eth_pkg holds:
  - State encodings.
  - CRC polynomial, init value and residue constants.
  - Preamble (0x5) and SFD (0xD) nibble constants.
  - ETH_FRAME_SIZE=1400, shared with the transmit side.
- Sub-module crc32_nibble: combinational next-CRC from (crc[31:0], nibble[3:0]). The transmit FCS logic reuses it.

## Test plan
- Good frame: 15 nibbles of 0x5, then 0xD, then payload bytes 0x00..0x3B, then the correct FCS → 64 writes to addresses 0..63; frame_valid pulse; frame_len=60.
- Same frame with the last FCS byte XOR 0x01 → frame_error; frame_len=60; no frame_valid.
- MII_RX_ER=1 for one cycle at byte 20 → frame_error; no further writes; DROP until DV falls, then IDLE.
- 1410-byte payload plus FCS → writes stop at address 1403; a single frame_error.
- Odd nibble count (DV falls after a lone nibble), and separately a 40-byte frame with a valid FCS → frame_error for each.
- Reset released while DV=1 mid-frame → no writes and no pulse; the next complete good frame → frame_valid.
